// File: rtl/mem_responder.sv
// mem_responder: memory target for the multicycle core's single-outstanding
// load/store port. It accepts rd/we with addr/data/size/sign, waits
// WAIT_CYCLES, then returns aligned and extended read data with a one-cycle
// ready strobe and an access-fault flag.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   rd, we                read / write request (a new request in IDLE only)
//   addr [31:0]           byte address
//   data [31:0]           right-justified write data
//   size [1:0]            00 byte, 01 half, 10 word, 11 illegal
//   sign                  1 = zero-extend reads, 0 = sign-extend
//   out  [31:0]           read data, held until the next successful read
//   error                 access fault, asserted only together with ready
//   ready                 one-cycle response strobe
`timescale 1ns/1ps
module mem_responder #(
   parameter int ADDR_WIDTH  = 14,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] data,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] out,
   output logic        error,
   output logic        ready
);

   localparam int AW = ADDR_WIDTH + 2;
   localparam logic [2:0] CNT_INIT =
      3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t state, state_nx;
   logic [2:0] cnt, cnt_nx;

   logic          rd_q, we_q, sign_q, fault_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   data_q;
   logic [1:0]    size_q;

   logic [31:0] mem [2**ADDR_WIDTH];

   logic          accept, fault_in;
   logic          cur_rd, cur_sign, cur_fault;
   logic [AW-1:0] cur_addr;
   logic [1:0]    cur_size;
   logic [31:0]   rword, rdata;
   logic          load_out;
   logic [3:0]    be;
   logic [31:0]   wlanes;

   function automatic logic fault_of(
      input logic        r,
      input logic        w,
      input logic [31:0] a,
      input logic [1:0]  sz
   );
      logic f;
      f = r & w;
      f = f | (sz == 2'b11);
      f = f | ((sz == 2'b01) && a[0]);
      f = f | ((sz == 2'b10) && (a[1:0] != 2'b00));
      // Anything above the RAM's byte range is a fault, not an alias.
      f = f | ((a >> AW) != 32'd0);
      return f;
   endfunction

   function automatic logic [31:0] extract(
      input logic [31:0] w,
      input logic [1:0]  lane,
      input logic [1:0]  sz,
      input logic        zx
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[8*lane +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   r = {{24{~zx & b[7]}}, b};
         2'b01:   r = {{16{~zx & h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   assign accept   = (state == IDLE) && (rd | we);
   assign fault_in = fault_of(rd, we, addr, size);

   // With WAIT_CYCLES=0 the RESP edge is the acceptance edge, so the
   // read path must see the live request rather than the latched copy.
   always_comb begin
      cur_rd    = rd_q;
      cur_sign  = sign_q;
      cur_fault = fault_q;
      cur_addr  = addr_q;
      cur_size  = size_q;
      if (state == IDLE) begin
         cur_rd    = rd;
         cur_sign  = sign;
         cur_fault = fault_in;
         cur_addr  = addr[AW-1:0];
         cur_size  = size;
      end
   end

   assign rword    = mem[cur_addr[AW-1:2]];
   assign rdata    = extract(rword, cur_addr[1:0], cur_size, cur_sign);
   assign load_out = (state_nx == RESP) && cur_rd && !cur_fault;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (rd | we) begin
               if (WAIT_CYCLES > 0) begin
                  state_nx = WAIT;
                  cnt_nx   = CNT_INIT;
               end else begin
                  state_nx = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt == 3'd0) begin
               state_nx = RESP;
            end else begin
               cnt_nx = cnt - 3'd1;
            end
         end
         RESP: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 3'd0;
         out     <= 32'd0;
         rd_q    <= 1'b0;
         we_q    <= 1'b0;
         sign_q  <= 1'b0;
         fault_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= 32'd0;
         size_q  <= 2'b00;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            rd_q    <= rd;
            we_q    <= we;
            sign_q  <= sign;
            fault_q <= fault_in;
            addr_q  <= addr[AW-1:0];
            data_q  <= data;
            size_q  <= size;
         end
         if (load_out) begin
            out <= rdata;
         end
      end
   end

   assign ready = (state == RESP);
   assign error = ready & fault_q;

   always_comb begin
      be     = 4'b1111;
      wlanes = data_q;
      case (size_q)
         2'b00: begin
            be     = 4'b0001 << addr_q[1:0];
            wlanes = {4{data_q[7:0]}};
         end
         2'b01: begin
            be     = addr_q[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{data_q[15:0]}};
         end
         default: begin
            be     = 4'b1111;
            wlanes = data_q;
         end
      endcase
   end

   // Commit on the edge that ends RESP; a reset on that edge drops it.
   always_ff @(posedge clk) begin
      if (!rst && state == RESP && we_q && !fault_q) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[addr_q[AW-1:2]][8*i +: 8] <= wlanes[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder with two instances,
// WAIT_CYCLES=2 (u2) and WAIT_CYCLES=0 (u0), sharing addr/data/size/sign/rst.
`timescale 1ns/1ps
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, data;
   logic [1:0]  size;
   logic        sign;
   logic        rd2, we2, rd0, we0;
   logic [31:0] out2, out0;
   logic        error2, error0, ready2, ready0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_responder #(.ADDR_WIDTH(14), .WAIT_CYCLES(2)) u2 (
      .clk(clk), .rst(rst), .rd(rd2), .we(we2), .addr(addr),
      .data(data), .size(size), .sign(sign),
      .out(out2), .error(error2), .ready(ready2)
   );

   mem_responder #(.ADDR_WIDTH(14), .WAIT_CYCLES(0)) u0 (
      .clk(clk), .rst(rst), .rd(rd0), .we(we0), .addr(addr),
      .data(data), .size(size), .sign(sign),
      .out(out0), .error(error0), .ready(ready0)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at the negedge of an IDLE cycle; returns at the negedge of
   // the IDLE cycle that follows RESP.
   task automatic xfer(input string tag, input bit sel0,
                       input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic sg,
                       input logic [31:0] exp_out, input logic exp_err,
                       input int exp_lat);
      int   lat;
      logic got, rdy, er;
      logic [31:0] o;
      addr = a; data = d; size = sz; sign = sg;
      if (sel0) begin rd0 = r; we0 = w; end
      else begin rd2 = r; we2 = w; end
      lat = 0; got = 1'b0; er = 1'b0; o = 32'd0;
      while (!got && lat < 20) begin
         @(negedge clk);
         lat++;
         rd0 = 1'b0; we0 = 1'b0; rd2 = 1'b0; we2 = 1'b0;
         rdy = sel0 ? ready0 : ready2;
         er  = sel0 ? error0 : error2;
         o   = sel0 ? out0 : out2;
         if (rdy) got = 1'b1;
         else check({tag, "_err_idle"}, 32'(er), 32'd0);
      end
      check({tag, "_ready_seen"}, 32'(got), 32'd1);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_err"}, 32'(er), 32'(exp_err));
      check({tag, "_out"}, o, exp_out);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; rd2 = 1'b0; we2 = 1'b0; rd0 = 1'b0; we0 = 1'b0;
      addr = 32'd0; data = 32'd0; size = 2'b10; sign = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out2", out2, 32'd0);
      check("rst_rdy2", 32'(ready2), 32'd0);
      check("rst_err2", 32'(error2), 32'd0);
      check("rst_out0", out0, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      xfer("w_word", 0, 0, 1, 32'h100, 32'hDEADBEEF, 2'b10, 0,
           32'h0, 0, 3);
      xfer("r_word", 0, 1, 0, 32'h100, 32'h0, 2'b10, 0,
           32'hDEADBEEF, 0, 3);
      xfer("w_byte", 0, 0, 1, 32'h102, 32'hFFFFFF55, 2'b00, 0,
           32'hDEADBEEF, 0, 3);
      xfer("r_b102", 0, 1, 0, 32'h102, 32'h0, 2'b00, 0,
           32'h00000055, 0, 3);
      xfer("r_h102s", 0, 1, 0, 32'h102, 32'h0, 2'b01, 0,
           32'hFFFFDE55, 0, 3);
      xfer("r_w100", 0, 1, 0, 32'h100, 32'h0, 2'b10, 0,
           32'hDE55BEEF, 0, 3);
      xfer("r_b103z", 0, 1, 0, 32'h103, 32'h0, 2'b00, 1,
           32'h000000DE, 0, 3);
      xfer("r_b103s", 0, 1, 0, 32'h103, 32'h0, 2'b00, 0,
           32'hFFFFFFDE, 0, 3);
      xfer("r_h100z", 0, 1, 0, 32'h100, 32'h0, 2'b01, 1,
           32'h0000BEEF, 0, 3);
      xfer("w_w104", 0, 0, 1, 32'h104, 32'h0, 2'b10, 0,
           32'h0000BEEF, 0, 3);
      xfer("w_h106", 0, 0, 1, 32'h106, 32'hABCD1234, 2'b01, 0,
           32'h0000BEEF, 0, 3);
      xfer("r_w104", 0, 1, 0, 32'h104, 32'h0, 2'b10, 0,
           32'h12340000, 0, 3);
      xfer("r_h106", 0, 1, 0, 32'h106, 32'h0, 2'b01, 0,
           32'h00001234, 0, 3);

      xfer("f_h101", 0, 1, 0, 32'h101, 32'h0, 2'b01, 0,
           32'h00001234, 1, 3);
      xfer("f_w102", 0, 0, 1, 32'h102, 32'h11111111, 2'b10, 0,
           32'h00001234, 1, 3);
      xfer("f_sz11", 0, 1, 0, 32'h100, 32'h0, 2'b11, 0,
           32'h00001234, 1, 3);
      xfer("f_rdwe", 0, 1, 1, 32'h100, 32'h0, 2'b10, 0,
           32'h00001234, 1, 3);
      xfer("f_oor_r", 0, 1, 0, 32'h00010000, 32'h0, 2'b10, 0,
           32'h00001234, 1, 3);
      xfer("f_oor_w", 0, 0, 1, 32'h00010100, 32'h22222222, 2'b10, 0,
           32'h00001234, 1, 3);
      xfer("f_rback", 0, 1, 0, 32'h100, 32'h0, 2'b10, 0,
           32'hDE55BEEF, 0, 3);

      xfer("w_top", 0, 0, 1, 32'h0000FFFC, 32'h89ABCDEF, 2'b10, 0,
           32'hDE55BEEF, 0, 3);
      xfer("r_top", 0, 1, 0, 32'h0000FFFC, 32'h0, 2'b10, 0,
           32'h89ABCDEF, 0, 3);
      xfer("r_topb", 0, 1, 0, 32'h0000FFFF, 32'h0, 2'b00, 0,
           32'hFFFFFF89, 0, 3);

      xfer("w0_word", 1, 0, 1, 32'h8, 32'hCAFEF00D, 2'b10, 0,
           32'h0, 0, 1);
      xfer("r0_word", 1, 1, 0, 32'h8, 32'h0, 2'b10, 0,
           32'hCAFEF00D, 0, 1);

      addr = 32'h8; size = 2'b10; sign = 1'b0; rd0 = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         check($sformatf("held_rdy_%0d", i), 32'(ready0),
               32'((i % 2) == 1));
      end
      rd0 = 1'b0;
      check("held_out", out0, 32'hCAFEF00D);
      @(negedge clk);
      check("held_stop", 32'(ready0), 32'd0);

      xfer("w_old40", 0, 0, 1, 32'h40, 32'hAAAAAAAA, 2'b10, 0,
           32'hFFFFFF89, 0, 3);
      addr = 32'h40; data = 32'h12345678; size = 2'b10; we2 = 1'b1;
      @(negedge clk);
      we2 = 1'b0;
      check("rstw_wait_rdy", 32'(ready2), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstw_out", out2, 32'd0);
      check("rstw_rdy", 32'(ready2), 32'd0);
      check("rstw_err", 32'(error2), 32'd0);
      xfer("rstw_rback", 0, 1, 0, 32'h40, 32'h0, 2'b10, 0,
           32'hAAAAAAAA, 0, 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Target side of the CPU data/instruction memory port. Accepts the single-outstanding request the multicycle core issues (rd/we, addr, data, size, sign), services it from an internal word-organised RAM after a configurable wait, and returns aligned/extended read data plus an error flag, qualified by a one-cycle `ready` pulse. It replaces the fixed-latency memory so the control unit can be exercised against wait states and access faults.

## Interface
- `ADDR_WIDTH`, 14, word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words
- `WAIT_CYCLES`, 1, extra cycles between acceptance and response; legal 0..7
- `clk` input 1 system clock, all logic on rising edge
- `rst` input 1 synchronous, active-high reset
- `rd` input 1 read request
- `we` input 1 write request
- `addr` input 32 byte address
- `data` input 32 write data, right-justified (byte in [7:0], half in [15:0])
- `size` input 2 00 byte, 01 half, 10 word, 11 illegal
- `sign` input 1 1 = zero-extend reads (funct3[2]), 0 = sign-extend
- `out` output 32 read data, held until the next successful read
- `error` output 1 access fault, valid only with `ready`
- `ready` output 1 one-cycle response strobe

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if `rd|we`, latch addr, data, size, sign, rd, we; compute fault; go WAIT if WAIT_CYCLES>0 else RESP. Otherwise stay.
- WAIT: counter loaded with WAIT_CYCLES-1 on acceptance, decrements each cycle; at 0 go RESP. Inputs ignored.
- RESP: `ready`=1 for exactly this cycle; `error`=fault. Next state always IDLE.
- Fault (any ⇒ no RAM access): `rd&we`; size=11; size=01 with addr[0]=1; size=10 with addr[1:0]≠0; addr[31:ADDR_WIDTH+2]≠0.
- Read: word at addr[ADDR_WIDTH+1:2]; select byte lane addr[1:0] or half lane addr[1]; extend per `sign`; register into `out` on the RESP→IDLE edge... precisely: `out` updated on the edge entering RESP so it is valid while `ready`=1.
- Faulted read: `out` keeps previous value.
- Write: byte enables from size/addr[1:0]; data lanes shifted from right-justified `data`; RAM updated on the clock edge ending RESP. Faulted write: RAM unchanged.
- RAM contents are not reset; initial contents undefined (bench may preload).

## Timing
- Reset: state IDLE, `out`=0, `error`=0, `ready`=0, counter 0. Reset in WAIT/RESP abandons the request; a pending write is not committed.
- Latency: request sampled in IDLE at cycle t ⇒ `ready` at t+1+WAIT_CYCLES.
- Single outstanding request; requester holds or drops rd/we freely after acceptance. Any rd/we seen in IDLE (including the cycle after RESP) is a new request, so the requester must deassert by the RESP cycle to avoid a repeat.
- Minimum request spacing: 2+WAIT_CYCLES cycles (back-to-back).
- Read-after-write to same address: the read accepted after the write's RESP returns the new data.
- `error` is 0 whenever `ready`=0.

## Test plan
- WAIT_CYCLES=2: word write 0xDEADBEEF to 0x100, then word read 0x100 → `ready` 3 cycles after each acceptance, `out`=0xDEADBEEF, `error`=0.
- Byte/half lanes: after above, byte write 0x55 to 0x102; read byte 0x102 sign=0 → 0x00000055; read half 0x102 sign=0 → 0xFFFFDE55... verify word 0x100 reads 0xDE55BEEF; read byte 0x103 sign=1 → 0x000000DE, sign=0 → 0xFFFFFFDE.
- Faults: half read at 0x101, word write at 0x102, size=11, rd&we, addr=0x0001_0000 (ADDR_WIDTH=14) → each `error`=1 with `ready`, `out` unchanged, RAM word unchanged on readback.
- WAIT_CYCLES=0: read accepted at t → `ready` at t+1; rd held high continuously → `ready` every 2 cycles.
- Reset mid-write: word write 0x12345678 to 0x40 over old 0xAAAAAAAA, assert `rst` in WAIT → outputs 0, state IDLE; readback of 0x40 = 0xAAAAAAAA.
